// File: rtl/snake_pkg.sv
// Shared types and constants for the snake step sequencer.
// Direction and MSM codes, sequencer states, period arithmetic.
package snake_pkg;

  localparam int PERIOD_W = 24;
  localparam int CALC_W   = 27;

  typedef logic [1:0] dir_t;
  localparam dir_t DIR_UP    = 2'b00;
  localparam dir_t DIR_LEFT  = 2'b01;
  localparam dir_t DIR_RIGHT = 2'b10;
  localparam dir_t DIR_DOWN  = 2'b11;

  typedef logic [1:0] msm_t;
  localparam msm_t MSM_IDLE = 2'b00;
  localparam msm_t MSM_PLAY = 2'b01;
  localparam msm_t MSM_WIN  = 2'b10;
  localparam msm_t MSM_LOSE = 2'b11;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_WAIT_TICK,
    SEQ_REQ,
    SEQ_WAIT_ACK
  } seq_state_t;

  // max(base - level*dec, min_p) without ever going negative
  function automatic logic [PERIOD_W-1:0] speed_period(
    input logic [PERIOD_W-1:0] base,
    input logic [PERIOD_W-1:0] min_p,
    input logic [PERIOD_W-1:0] dec,
    input logic [2:0]          level
  );
    logic [CALC_W-1:0] drop;
    logic [CALC_W-1:0] floor_sum;
    logic [CALC_W-1:0] diff;
    drop      = CALC_W'(level) * CALC_W'(dec);
    floor_sum = drop + CALC_W'(min_p);
    diff      = CALC_W'(base) - drop;
    if (floor_sum >= CALC_W'(base)) begin
      return min_p;
    end
    return diff[PERIOD_W-1:0];
  endfunction

endpackage

// File: rtl/snake_step_sequencer_timer.sv
// Step tick timer: counts 0..period, reloads period on expiry.
// Clear forces count to 0 and restores the level-0 period.
module step_period_timer
  import snake_pkg::*;
#(
  parameter logic [PERIOD_W-1:0] INIT_PERIOD = 24'd3999999
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                clear,
  input  logic [PERIOD_W-1:0] next_period,
  output logic                expire
);

  logic [PERIOD_W-1:0] count_q;
  logic [PERIOD_W-1:0] period_q;

  assign expire = !clear && (count_q == period_q);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count_q  <= '0;
      period_q <= INIT_PERIOD;
    end else if (clear) begin
      count_q  <= '0;
      period_q <= INIT_PERIOD;
    end else if (expire) begin
      count_q  <= '0;
      period_q <= next_period;
    end else begin
      count_q  <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/snake_step_sequencer.sv
// Snake step sequencer: tick, direction commit, STEP_REQ/ACK.
// Define SNAKE_SPEEDUP_EN to enable target-driven speed levels.
module snake_step_sequencer
  import snake_pkg::*;
#(
  parameter logic [PERIOD_W-1:0] BASE_PERIOD = 24'd3999999,
  parameter logic [PERIOD_W-1:0] MIN_PERIOD  = 24'd999999,
  parameter logic [PERIOD_W-1:0] PERIOD_DEC  = 24'd400000,
  parameter logic [2:0]          MAX_LEVEL   = 3'd7
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [1:0]  MSM_STATE,
  input  logic        BTN_DIR_VALID,
  input  logic [1:0]  BTN_DIR,
  input  logic        TARGET_REACHED,
  input  logic        STEP_ACK,
  output logic        STEP_REQ,
  output logic [1:0]  NAV_STATE,
  output logic [2:0]  SPEED_LEVEL,
  output logic [15:0] STEP_COUNT,
  output logic        OVERRUN
);

  seq_state_t state_q;
  seq_state_t state_d;

  logic                play;
  logic                expire;
  logic                tmr_clear;
  logic                in_req;
  logic                in_ack_wait;
  logic                ack_done;
  logic                press_ok;
  dir_t                ref_dir;
  dir_t                nav_q;
  dir_t                pend_dir_q;
  logic                pend_vld_q;
  logic [15:0]         count_q;
  logic                over_q;
  logic [2:0]          level_q;
  logic [PERIOD_W-1:0] next_period;

  assign play = (MSM_STATE == MSM_PLAY);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= SEQ_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!play) begin
      state_d = SEQ_IDLE;
    end else begin
      unique case (state_q)
        SEQ_IDLE:      state_d = SEQ_WAIT_TICK;
        SEQ_WAIT_TICK: if (expire) state_d = SEQ_REQ;
        SEQ_REQ:       state_d = SEQ_WAIT_ACK;
        SEQ_WAIT_ACK:  if (STEP_ACK) state_d = SEQ_WAIT_TICK;
      endcase
    end
  end

  always_comb begin
    tmr_clear   = 1'b0;
    in_req      = 1'b0;
    in_ack_wait = 1'b0;
    unique case (state_q)
      SEQ_IDLE:      tmr_clear   = 1'b1;
      SEQ_WAIT_TICK: tmr_clear   = 1'b0;
      SEQ_REQ:       in_req      = 1'b1;
      SEQ_WAIT_ACK:  in_ack_wait = 1'b1;
    endcase
    if (!play) begin
      tmr_clear = 1'b1;
    end
  end

  step_period_timer #(
    .INIT_PERIOD (BASE_PERIOD)
  ) u_timer (
    .CLK         (CLK),
    .RESET       (RESET),
    .clear       (tmr_clear),
    .next_period (next_period),
    .expire      (expire)
  );

  // A press during the commit cycle is judged against the new heading
  assign ref_dir  = (in_req && pend_vld_q) ? pend_dir_q : nav_q;
  assign press_ok = BTN_DIR_VALID
                 && (BTN_DIR != ~ref_dir)
                 && (BTN_DIR != ref_dir);
  assign ack_done = play && in_ack_wait && STEP_ACK;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      nav_q      <= DIR_RIGHT;
      pend_dir_q <= DIR_RIGHT;
      pend_vld_q <= 1'b0;
      count_q    <= '0;
      over_q     <= 1'b0;
    end else if (!play) begin
      pend_vld_q <= 1'b0;
    end else if (state_q == SEQ_IDLE) begin
      nav_q      <= DIR_RIGHT;
      pend_vld_q <= 1'b0;
      count_q    <= '0;
      over_q     <= 1'b0;
    end else begin
      if (in_req && pend_vld_q) begin
        nav_q <= pend_dir_q;
      end
      if (press_ok) begin
        pend_vld_q <= 1'b1;
        pend_dir_q <= BTN_DIR;
      end else if (in_req) begin
        pend_vld_q <= 1'b0;
      end
      if (ack_done) begin
        count_q <= count_q + 16'd1;
      end
      if (in_ack_wait && expire) begin
        over_q <= 1'b1;
      end
    end
  end

`ifdef SNAKE_SPEEDUP_EN
  logic tr_q;
  logic tr_rise;

  assign tr_rise = TARGET_REACHED && !tr_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tr_q    <= 1'b0;
      level_q <= '0;
    end else begin
      tr_q <= TARGET_REACHED;
      if (play && state_q == SEQ_IDLE) begin
        level_q <= '0;
      end else if (play && tr_rise && level_q < MAX_LEVEL) begin
        level_q <= level_q + 3'd1;
      end
    end
  end

  assign next_period = speed_period(BASE_PERIOD, MIN_PERIOD,
                                    PERIOD_DEC, level_q);
`else
  logic speedup_unused;

  assign speedup_unused = ^{TARGET_REACHED, MIN_PERIOD,
                            PERIOD_DEC, MAX_LEVEL};
  assign level_q        = '0;
  assign next_period    = BASE_PERIOD;
`endif

  assign STEP_REQ    = in_ack_wait;
  assign NAV_STATE   = nav_q;
  assign SPEED_LEVEL = level_q;
  assign STEP_COUNT  = count_q;
  assign OVERRUN     = over_q;

endmodule
